// File: rtl/boot_rom_loader.sv
// Boot ROM loader: copies NUM_WORDS 32-bit words from a synchronous ROM into RAM
// starting at byte address RAM_BASE, accumulates a checksum, then enables core fetch.
module boot_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [31:0]           rom_rdata_i,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic                  ram_gnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fetch_en_o,
  output logic [31:0]           checksum_o
);

  // One extra index bit so NUM_WORDS = 2^ADDR_WIDTH never wraps the counter.
  localparam int unsigned         IDX_W    = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           sum_q, sum_d;
  logic                  done_q, done_d;

  // Output flops are loaded from the next state so every port is a register output.
  logic                  rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  ram_req_q, ram_req_d;
  logic [31:0]           ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic                  busy_q, busy_d;

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      ram_req_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      ram_req_q   <= ram_req_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath update and next-output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    sum_d       = sum_q;
    done_d      = done_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = '0;
    ram_req_d   = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    busy_d      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = READ;
          idx_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        buf_d   = rom_rdata_i;
        sum_d   = sum_q + rom_rdata_i;
        state_d = WRITE;
      end
      WRITE: begin
        if (ram_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = READ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rom_en_d = (state_d == READ);
    if (state_d == READ) begin
      rom_addr_d = idx_d[ADDR_WIDTH-1:0];
    end
    ram_req_d = (state_d == WRITE);
    if (state_d == WRITE) begin
      ram_addr_d  = RAM_BASE + (32'(idx_d) << 2);
      ram_wdata_d = buf_d;
    end
    busy_d = (state_d == READ) || (state_d == CAPTURE) || (state_d == WRITE);
  end

  assign rom_en_o    = rom_en_q;
  assign rom_addr_o  = rom_addr_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_req_q;
  assign ram_be_o    = {4{ram_req_q}};
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fetch_en_o  = done_q;
  assign checksum_o  = sum_q;

endmodule

// File: doc/boot_rom_loader.md
BOOT_ROM_LOADER -- requirements
Module: boot_rom_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, which is the ROM word-address width.
REQ-002 The block SHALL have parameter NUM_WORDS, default 1024, which is the number of words to copy (legal range 1..2^ADDR_WIDTH).
REQ-003 The block SHALL have parameter RAM_BASE, default 32'h0000_0000, which is the byte address of the destination for ROM word 0.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset. All ports are listed below.
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start_i, input, 1: copy request; sampled high for one cycle.
- rom_en_o, output, 1: ROM read enable.
- rom_addr_o, output, ADDR_WIDTH: ROM word address.
- rom_rdata_i, input, 32: ROM read data, valid the cycle after rom_en_o.
- ram_req_o, output, 1: RAM write request.
- ram_we_o, output, 1: RAM write enable; equals ram_req_o.
- ram_be_o, output, 4: byte enables; 4'hF when ram_req_o=1, else 0.
- ram_addr_o, output, 32: RAM byte address.
- ram_wdata_o, output, 32: RAM write data.
- ram_gnt_i, input, 1: RAM grant; the write completes in a cycle where ram_req_o=1 and ram_gnt_i=1.
- busy_o, output, 1: high while a copy is in progress.
- done_o, output, 1: sticky completion flag.
- fetch_en_o, output, 1: core fetch enable; equals done_o.
- checksum_o, output, 32: running sum of the copied words.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, READ, CAPTURE, WRITE and DONE.
REQ-006 IDLE: all outputs SHALL be 0. If start_i=1, the FSM SHALL go to READ, clear the word index, clear checksum and clear done.
REQ-007 READ: rom_en_o SHALL be 1 and rom_addr_o SHALL equal the word index, for exactly one cycle. The FSM then goes to CAPTURE.
REQ-008 CAPTURE: rom_rdata_i SHALL be registered into the write-data buffer. checksum SHALL become checksum + rom_rdata_i, modulo 2^32. The FSM then goes to WRITE.
REQ-009 WRITE: ram_req_o SHALL be 1, with ram_addr_o = RAM_BASE + 4*index (32-bit wrap) and ram_wdata_o = the buffer.
REQ-010 WRITE: req, addr, wdata and be SHALL stay stable until the grant cycle. There SHALL be no timeout.
REQ-011 WRITE grant cycle, index < NUM_WORDS-1: the index SHALL increment and the FSM SHALL go to READ.
REQ-012 WRITE grant cycle, index = NUM_WORDS-1: the FSM SHALL go to DONE and done SHALL be set in the same edge.
REQ-013 In the cycle after any grant, ram_req_o SHALL be 0.
REQ-014 busy_o SHALL be 1 in READ, CAPTURE and WRITE, and 0 in IDLE and DONE.
REQ-015 rom_en_o SHALL be 0 in every state except READ. rom_addr_o SHALL be don't-care outside READ, but SHALL be driven to 0 in IDLE.
REQ-016 start_i SHALL be ignored while busy_o=1.
REQ-017 DONE with start_i=1: the block SHALL restart exactly as from IDLE; done_o drops in the next cycle.
REQ-018 DONE without start_i: the FSM SHALL hold. done_o, fetch_en_o and checksum_o SHALL hold their values.
REQ-019 The index counter width SHALL be ADDR_WIDTH+1, so no overflow is possible when NUM_WORDS = 2^ADDR_WIDTH.
REQ-020 With ram_gnt_i held at 1, latency from the start_i edge to done_o=1 SHALL be exactly 3*NUM_WORDS cycles.
REQ-021 Every cycle of grant stall SHALL add exactly one cycle to the REQ-020 latency.

Reset
REQ-022 While rst=1, regardless of clk, the FSM SHALL be IDLE, and index, buffer, checksum and done SHALL be 0.
REQ-023 While rst=1, all outputs SHALL be 0.
REQ-024 Reset asserted mid-copy SHALL abort immediately. ram_req_o SHALL drop without waiting for a grant.
REQ-025 After reset is released, the block SHALL wait in IDLE for start_i.

Verification
REQ-026 NUM_WORDS=4, ROM[i]=32'h1000_0000+i, gnt tied 1, start pulse -> four writes to addresses 0x0,0x4,0x8,0xC with matching data; done_o=1 exactly 12 cycles after start; checksum_o=32'h4000_0006.
REQ-027 Same as REQ-026, but with gnt held low for 5 cycles on the second write -> req, addr 0x4 and data 32'h1000_0001 stable for all 6 cycles; done after 17 cycles.
REQ-028 start_i pulsed in CAPTURE and again in WRITE -> ignored; exactly NUM_WORDS writes occur.
REQ-029 After DONE, pulse start_i -> done_o=0 the next cycle; the copy repeats; the final checksum is identical.
REQ-030 Assert rst during WRITE of word 2 -> ram_req_o=0 and busy_o=0 without waiting for a clock; after release no activity until start_i.
REQ-031 NUM_WORDS=1, ROM[0]=32'hFFFF_FFFF, RAM_BASE=32'hFFFF_FFFC -> one write to 0xFFFF_FFFC; checksum 32'hFFFF_FFFF; done after 3 cycles.
